// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU/PC codes, FSM states and instruction field positions.
package cpu_pkg;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_MVI  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADI  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SUI  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WAIT, ST_NEXT, ST_HALT, ST_ERR
  } state_t;
  function automatic logic [3:0] onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode decode into ALU controls and instruction class flags.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_func,
  output logic       alu_in_sel,
  output logic       is_alu,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_halt
);
  always_comb begin
    alu_func   = ALU_PASS;
    alu_in_sel = 1'b0;
    is_alu     = 1'b0;
    is_jmp     = 1'b0;
    is_jz      = 1'b0;
    is_halt    = 1'b0;
    case (opcode)
      OP_MOV:  is_alu = 1'b1;
      OP_MVI:  begin is_alu = 1'b1; alu_in_sel = 1'b1; end
      OP_ADD:  begin is_alu = 1'b1; alu_func = ALU_ADD; end
      OP_ADI:  begin is_alu = 1'b1; alu_func = ALU_ADD; alu_in_sel = 1'b1; end
      OP_SUB:  begin is_alu = 1'b1; alu_func = ALU_SUB; end
      OP_SUI:  begin is_alu = 1'b1; alu_func = ALU_SUB; alu_in_sel = 1'b1; end
      OP_AND:  begin is_alu = 1'b1; alu_func = ALU_AND; end
      OP_OR:   begin is_alu = 1'b1; alu_func = ALU_OR; end
      OP_JMP:  is_jmp = 1'b1;
      OP_JZ:   is_jz = 1'b1;
      OP_HALT: is_halt = 1'b1;
      OP_NOP:  ;
      default: ; // opcodes B-E behave as NOP
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving the datapath handshake and PC update.
module control_unit
  import cpu_pkg::*;
#(
  parameter int WD_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        dp_done,
  input  logic        alu_zero,
  output logic        en_pc_pulse,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic [7:0]  offset,
  output logic        en_in,
  output logic [3:0]  reg_en,
  output logic        alu_in_sel,
  output logic [2:0]  alu_func,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic        halted,
  output logic        err
);
  localparam int CW = $clog2(WD_LIMIT + 1);
  state_t         state, state_nx;
  logic [15:0]    ir_q;
  logic           is_jmp_q, is_jz_q, z;
  logic [CW-1:0]  wd;
  logic           wd_hit;
  logic [2:0]     dec_func;
  logic           dec_sel, dec_alu, dec_jmp, dec_jz, dec_halt;

  instr_decode u_dec (
    .opcode     (ir_q[OPC_MSB:OPC_LSB]),
    .alu_func   (dec_func),
    .alu_in_sel (dec_sel),
    .is_alu     (dec_alu),
    .is_jmp     (dec_jmp),
    .is_jz      (dec_jz),
    .is_halt    (dec_halt)
  );

  assign wd_hit = wd == CW'(WD_LIMIT - 1);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;

  // dp_done wins over the watchdog in the final WAIT cycle
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = start ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: state_nx = dec_halt ? ST_HALT : dec_alu ? ST_EXEC : ST_NEXT;
      ST_EXEC:   state_nx = ST_WAIT;
      ST_WAIT:   state_nx = dp_done ? ST_NEXT : wd_hit ? ST_ERR : ST_WAIT;
      ST_NEXT:   state_nx = ST_FETCH;
      default:   state_nx = state;
    endcase
    en_in       = state == ST_EXEC;
    en_pc_pulse = state == ST_NEXT;
    pc_ctrl     = state != ST_NEXT ? PC_HOLD : (is_jmp_q || (is_jz_q && z)) ? PC_LOAD : PC_INC;
    reg_en      = (state == ST_DECODE && dec_alu) ? onehot(ir_q[RD_MSB:RD_LSB]) :
                  (state == ST_EXEC || state == ST_WAIT) ? onehot(rd) : 4'b0000;
    halted      = state == ST_HALT;
    err         = state == ST_ERR;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ir_q        <= '0;
      rd          <= '0;
      rs          <= '0;
      alu_func    <= ALU_PASS;
      alu_in_sel  <= 1'b0;
      offset      <= '0;
      offset_addr <= '0;
      is_jmp_q    <= 1'b0;
      is_jz_q     <= 1'b0;
      z           <= 1'b0;
      wd          <= '0;
    end else begin
      if (state == ST_FETCH) ir_q <= ir;
      if (state == ST_DECODE) begin
        rd          <= ir_q[RD_MSB:RD_LSB];
        rs          <= ir_q[RS_MSB:RS_LSB];
        alu_func    <= dec_func;
        alu_in_sel  <= dec_sel;
        offset      <= ir_q[IMM_MSB:IMM_LSB];
        offset_addr <= ir_q[IMM_MSB:IMM_LSB];
        is_jmp_q    <= dec_jmp;
        is_jz_q     <= dec_jz;
      end
      if (state == ST_EXEC) wd <= '0;
      else if (state == ST_WAIT && !dp_done) wd <= wd + 1'b1;
      if (state == ST_WAIT && dp_done) z <= alu_zero;
    end
endmodule
